// File: rtl/monoflop_array.sv
// Multi-channel one-shot: per-channel trigger synchroniser, rising-edge detect and a
// pulse/hold-off FSM with optional retrigger and a sticky missed-trigger flag.
module monoflop_array #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [CHANNELS-1:0]    i_enable,
  input  logic [CHANNELS-1:0]    i_trigger,
  input  logic [COUNT_WIDTH-1:0] i_width,
  input  logic [COUNT_WIDTH-1:0] i_holdoff,
  input  logic                   i_retrigger,
  input  logic                   i_clear_missed,
  output logic [CHANNELS-1:0]    o_q,
  output logic [CHANNELS-1:0]    o_busy,
  output logic [CHANNELS-1:0]    o_missed
);

  typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_e;

  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
  logic [CHANNELS-1:0]    r_prev;
  state_e                 r_state [CHANNELS];
  logic [COUNT_WIDTH-1:0] r_cnt [CHANNELS];
  logic [CHANNELS-1:0]    r_q;
  logic [CHANNELS-1:0]    r_busy;
  logic [CHANNELS-1:0]    r_missed;

  logic [CHANNELS-1:0]    w_sync_out;
  logic [CHANNELS-1:0]    w_edge;
  state_e                 w_state_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] w_cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    w_missed_set;
  logic [CHANNELS-1:0]    w_q_d;
  logic [CHANNELS-1:0]    w_busy_d;
  logic [CHANNELS-1:0]    w_missed_d;

  always_comb begin
    w_sync_out = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_sync_out[c] = r_sync[c][SYNC_STAGES-1];
    end
    w_edge = w_sync_out & ~r_prev;
  end

  always_comb begin
    w_missed_set = '0;
    w_q_d        = '0;
    w_busy_d     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_state_d[c] = r_state[c];
      w_cnt_d[c]   = r_cnt[c];
      unique case (r_state[c])
        StIdle: begin
          if (w_edge[c] && i_enable[c]) begin
            if (i_width != '0) begin
              w_state_d[c] = StPulse;
              w_cnt_d[c]   = i_width - CntOne;
            end else begin
              w_missed_set[c] = 1'b1;
            end
          end
        end
        StPulse: begin
          if (!i_enable[c]) begin
            w_state_d[c] = StIdle;
          end else begin
            if (w_edge[c] && !i_retrigger) w_missed_set[c] = 1'b1;
            if (w_edge[c] && i_retrigger && (i_width != '0)) begin
              w_cnt_d[c] = i_width - CntOne;
            end else if ((w_edge[c] && i_retrigger) || (r_cnt[c] == '0)) begin
              // A zero-width retrigger terminates the pulse through the normal exit path.
              if (i_holdoff != '0) begin
                w_state_d[c] = StHoldoff;
                w_cnt_d[c]   = i_holdoff - CntOne;
              end else begin
                w_state_d[c] = StIdle;
              end
            end else begin
              w_cnt_d[c] = r_cnt[c] - CntOne;
            end
          end
        end
        StHoldoff: begin
          if (!i_enable[c]) begin
            w_state_d[c] = StIdle;
          end else begin
            if (w_edge[c]) w_missed_set[c] = 1'b1;
            if (r_cnt[c] == '0) w_state_d[c] = StIdle;
            else                w_cnt_d[c]   = r_cnt[c] - CntOne;
          end
        end
        default: w_state_d[c] = StIdle;
      endcase
      w_q_d[c]    = (w_state_d[c] == StPulse);
      w_busy_d[c] = (w_state_d[c] != StIdle);
    end
    // A new miss in the same cycle beats the clear request.
    w_missed_d = w_missed_set | (r_missed & ~{CHANNELS{i_clear_missed}});
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Synchroniser and edge register load 1 so a trigger held through reset never fires.
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_sync[c]  <= '1;
        r_state[c] <= StIdle;
        r_cnt[c]   <= '0;
      end
      r_prev   <= '1;
      r_q      <= '0;
      r_busy   <= '0;
      r_missed <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_sync[c]  <= {r_sync[c][SYNC_STAGES-2:0], i_trigger[c]};
        r_state[c] <= w_state_d[c];
        r_cnt[c]   <= w_cnt_d[c];
      end
      r_prev   <= w_sync_out;
      r_q      <= w_q_d;
      r_busy   <= w_busy_d;
      r_missed <= w_missed_d;
    end
  end

  assign o_q      = r_q;
  assign o_busy   = r_busy;
  assign o_missed = r_missed;

endmodule
